// File: rtl/mem_io_init.sv
// Command-driven word mover between a cmd/stream interface and the mem_wrap IO_CTRL port.
// Define MEM_IO_INIT_ADDR_CHK_EN to enable in-order checking of read response addresses.
`timescale 1ns/1ps

package ss_rvc_pkg;
  typedef enum logic [0:0] {RD = 1'b0, WR = 1'b1} t_opcode;
endpackage

module mem_io_init
  import ss_rvc_pkg::*;
(
  input  logic        QClk,
  input  logic        RstQnnnH,
  input  logic        CmdValidQnnnH,
  output logic        CmdReadyQnnnH,
  input  t_opcode     CmdOpcodeQnnnH,
  input  logic [31:0] CmdAddressQnnnH,
  input  logic [7:0]  CmdLengthQnnnH,
  input  logic        WrValidQnnnH,
  output logic        WrReadyQnnnH,
  input  logic [31:0] WrDataQnnnH,
  output logic        RdValidQnnnH,
  input  logic        RdReadyQnnnH,
  output logic [31:0] RdDataQnnnH,
  output logic        ReqValidQ501H,
  output t_opcode     ReqOpcodeQ501H,
  output logic [31:0] ReqAddressQ501H,
  output logic [31:0] ReqDataQ501H,
  input  logic        RspValidQ502H,
  input  t_opcode     RspOpcodeQ502H,
  input  logic [31:0] RspAddressQ502H,
  input  logic [31:0] RspDataQ502H,
  output logic        BusyQnnnH,
  output logic        DoneQnnnH,
  output logic        ErrQnnnH,
  output logic [31:0] ErrAddrQnnnH
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  t_opcode           op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        remain_q, remain_d;
  logic [2:0]        outst_q, outst_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0][31:0]  fifo_q, fifo_d;

  logic cmd_accept, rsp_push, rd_pop, rd_issue, credit_ok;

  assign CmdReadyQnnnH = (state_q == IDLE) && !RstQnnnH;
  assign cmd_accept    = CmdValidQnnnH && CmdReadyQnnnH;
  assign BusyQnnnH     = (state_q != IDLE);
  assign DoneQnnnH     = (state_q == DONE);
  assign RdValidQnnnH  = (cnt_q != 3'd0);
  assign RdDataQnnnH   = fifo_q[rptr_q];
  // Responses seen while idle belong to an aborted command and are dropped.
  assign rsp_push      = RspValidQ502H && (RspOpcodeQ502H == RD) && (state_q != IDLE);
  assign rd_pop        = RdValidQnnnH && RdReadyQnnnH;
  assign credit_ok     = ({1'b0, cnt_q} + {1'b0, outst_q}) < 4'd4;
  assign rd_issue      = ReqValidQ501H && (op_q == RD);

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    WrReadyQnnnH    = 1'b0;
    ReqValidQ501H   = 1'b0;
    ReqOpcodeQ501H  = op_q;
    ReqAddressQ501H = addr_q;
    ReqDataQ501H    = '0;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          op_d     = CmdOpcodeQnnnH;
          addr_d   = CmdAddressQnnnH;
          remain_d = CmdLengthQnnnH;
          state_d  = (CmdLengthQnnnH == 8'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (op_q == WR) begin
          WrReadyQnnnH  = 1'b1;
          ReqValidQ501H = WrValidQnnnH;
          ReqDataQ501H  = WrDataQnnnH;
        end else begin
          ReqValidQ501H = credit_ok;
        end
        if (ReqValidQ501H) begin
          addr_d   = addr_q + 32'd4;
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((outst_q == 3'd0) && (cnt_q == 3'd0)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outst_d = outst_q + {2'b0, rd_issue} - {2'b0, rsp_push};
    cnt_d   = cnt_q + {2'b0, rsp_push} - {2'b0, rd_pop};
    wptr_d  = wptr_q + {1'b0, rsp_push};
    rptr_d  = rptr_q + {1'b0, rd_pop};
    fifo_d  = fifo_q;
    if (rsp_push) fifo_d[wptr_q] = RspDataQ502H;
  end

  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      state_q  <= IDLE;
      op_q     <= RD;
      addr_q   <= '0;
      remain_q <= '0;
      outst_q  <= '0;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fifo_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      outst_q  <= outst_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fifo_q   <= fifo_d;
    end
  end

`ifdef MEM_IO_INIT_ADDR_CHK_EN
  logic [31:0] exp_q, exp_d, err_addr_q, err_addr_d;
  logic        err_q, err_d;

  // Only the first mismatch is captured; later ones leave the record intact.
  always_comb begin
    exp_d      = exp_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (cmd_accept) begin
      exp_d = CmdAddressQnnnH;
    end else if (rsp_push) begin
      exp_d = exp_q + 32'd4;
      if (!err_q && (RspAddressQ502H != exp_q)) begin
        err_d      = 1'b1;
        err_addr_d = RspAddressQ502H;
      end
    end
  end

  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      exp_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      exp_q      <= exp_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign ErrQnnnH     = err_q;
  assign ErrAddrQnnnH = err_addr_q;
`else
  logic unused_rsp_addr;
  assign unused_rsp_addr = ^RspAddressQ502H;
  assign ErrQnnnH        = 1'b0;
  assign ErrAddrQnnnH    = '0;
`endif

endmodule

// File: tb/tb_mem_io_init.sv
// Bench for mem_io_init: vector table, randomized commands against a mem_wrap model
// with random response latency, and hand sequences for backpressure, len 0, reset, errors.
`timescale 1ns/1ps

module tb_mem_io_init;
  import ss_rvc_pkg::*;

  logic        QClk = 1'b0;
  logic        RstQnnnH = 1'b1;
  logic        CmdValidQnnnH = 1'b0;
  logic        CmdReadyQnnnH;
  t_opcode     CmdOpcodeQnnnH = RD;
  logic [31:0] CmdAddressQnnnH = '0;
  logic [7:0]  CmdLengthQnnnH = '0;
  logic        WrValidQnnnH = 1'b0;
  logic        WrReadyQnnnH;
  logic [31:0] WrDataQnnnH = '0;
  logic        RdValidQnnnH;
  logic        RdReadyQnnnH = 1'b0;
  logic [31:0] RdDataQnnnH;
  logic        ReqValidQ501H;
  t_opcode     ReqOpcodeQ501H;
  logic [31:0] ReqAddressQ501H, ReqDataQ501H;
  logic        RspValidQ502H = 1'b0;
  t_opcode     RspOpcodeQ502H = RD;
  logic [31:0] RspAddressQ502H = '0, RspDataQ502H = '0;
  logic        BusyQnnnH, DoneQnnnH, ErrQnnnH;
  logic [31:0] ErrAddrQnnnH;

  mem_io_init dut (
    .QClk(QClk), .RstQnnnH(RstQnnnH),
    .CmdValidQnnnH(CmdValidQnnnH), .CmdReadyQnnnH(CmdReadyQnnnH),
    .CmdOpcodeQnnnH(CmdOpcodeQnnnH), .CmdAddressQnnnH(CmdAddressQnnnH),
    .CmdLengthQnnnH(CmdLengthQnnnH),
    .WrValidQnnnH(WrValidQnnnH), .WrReadyQnnnH(WrReadyQnnnH), .WrDataQnnnH(WrDataQnnnH),
    .RdValidQnnnH(RdValidQnnnH), .RdReadyQnnnH(RdReadyQnnnH), .RdDataQnnnH(RdDataQnnnH),
    .ReqValidQ501H(ReqValidQ501H), .ReqOpcodeQ501H(ReqOpcodeQ501H),
    .ReqAddressQ501H(ReqAddressQ501H), .ReqDataQ501H(ReqDataQ501H),
    .RspValidQ502H(RspValidQ502H), .RspOpcodeQ502H(RspOpcodeQ502H),
    .RspAddressQ502H(RspAddressQ502H), .RspDataQ502H(RspDataQ502H),
    .BusyQnnnH(BusyQnnnH), .DoneQnnnH(DoneQnnnH),
    .ErrQnnnH(ErrQnnnH), .ErrAddrQnnnH(ErrAddrQnnnH)
  );

  always #5 QClk = ~QClk;

  int checks = 0;
  int passes = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // mem_wrap model state and observation logs
  typedef struct { t_opcode op; logic [31:0] addr; logic [31:0] data; } req_t;
  typedef struct { t_opcode op; logic [31:0] addr; logic [31:0] data; longint due; } rsp_t;
  logic [31:0] d_mem [logic [31:0]];
  req_t        req_log[$];
  rsp_t        pend[$];
  logic [31:0] rd_log[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wr_data[$];
  int  done_cnt = 0, credit_viol = 0, wr_idx = 0, wr_len = 0, rd_pct = 0;
  int  corrupt_n = -1, rd_rsp_n = 0, issued_rd = 0, popped = 0;
  bit  wr_active = 1'b0;
  longint cyc = 0, last_due = 0;

  always @(negedge QClk) begin
    longint due;
    if (!RstQnnnH) begin
      if (DoneQnnnH) done_cnt++;
      if (ReqValidQ501H) begin
        req_log.push_back('{ReqOpcodeQ501H, ReqAddressQ501H, ReqDataQ501H});
        due = cyc + 1 + longint'($urandom_range(0, 4));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        if (ReqOpcodeQ501H == RD) begin
          if (issued_rd - popped >= 4) credit_viol++;
          issued_rd++;
          pend.push_back('{RD, ReqAddressQ501H,
                           d_mem.exists(ReqAddressQ501H) ? d_mem[ReqAddressQ501H] : 32'h0, due});
        end else begin
          d_mem[ReqAddressQ501H] = ReqDataQ501H;
          pend.push_back('{WR, ReqAddressQ501H, ReqDataQ501H, due});
        end
      end
      if (RdValidQnnnH && RdReadyQnnnH) begin
        rd_log.push_back(RdDataQnnnH);
        popped++;
      end
      if (WrValidQnnnH && WrReadyQnnnH) wr_idx++;
    end
  end

  initial begin
    rsp_t r;
    forever begin
      @(posedge QClk);
      cyc++;
      #1;
      if (wr_active && wr_idx < wr_len) begin
        WrValidQnnnH = ($urandom_range(0, 99) < 70);
        WrDataQnnnH  = wr_data[wr_idx];
      end else begin
        WrValidQnnnH = 1'b0;
        WrDataQnnnH  = $urandom;
      end
      RdReadyQnnnH = ($urandom_range(0, 99) < rd_pct);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        RspValidQ502H   = 1'b1;
        RspOpcodeQ502H  = r.op;
        RspAddressQ502H = r.addr;
        RspDataQ502H    = r.data;
        if (r.op == RD) begin
          if (rd_rsp_n == corrupt_n) RspAddressQ502H = 32'hDEAD_0000;
          rd_rsp_n++;
        end
      end else begin
        RspValidQ502H   = 1'b0;
        RspOpcodeQ502H  = t_opcode'($urandom_range(0, 1));
        RspAddressQ502H = $urandom;
        RspDataQ502H    = $urandom;
      end
    end
  end

  task automatic start_cmd(t_opcode op, logic [31:0] addr, int len, int pct,
                           logic [31:0] d0, bit rnd_data);
    bit acc = 1'b0;
    logic [31:0] a;
    done_cnt = 0; credit_viol = 0; issued_rd = 0; popped = 0; rd_rsp_n = 0; wr_idx = 0;
    req_log.delete(); rd_log.delete(); exp_rd.delete(); wr_data.delete();
    for (int i = 0; i < len; i++) begin
      a = addr + 32'(4 * i);
      if (op == WR) wr_data.push_back(rnd_data ? $urandom : d0 + 32'(i));
      else begin
        if (!d_mem.exists(a)) d_mem[a] = $urandom;
        exp_rd.push_back(d_mem[a]);
      end
    end
    wr_len = (op == WR) ? len : 0;
    rd_pct = pct;
    wr_active = 1'b1;
    @(posedge QClk); #1;
    CmdValidQnnnH = 1'b1; CmdOpcodeQnnnH = op; CmdAddressQnnnH = addr; CmdLengthQnnnH = 8'(len);
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge QClk);
      acc = CmdReadyQnnnH;
    end
    @(posedge QClk); #1;
    CmdValidQnnnH = 1'b0; CmdAddressQnnnH = $urandom; CmdLengthQnnnH = 8'($urandom);
    check("cmd_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic finish_cmd(string tag, t_opcode op, logic [31:0] addr, int len,
                            logic [31:0] exp_last);
    int t = 0;
    int bad = 0;
    while (done_cnt == 0 && t < 3000) begin @(posedge QClk); t++; end
    repeat (3) @(posedge QClk);
    wr_active = 1'b0;
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_num_req"}, req_log.size(), len);
    for (int i = 0; i < req_log.size(); i++) begin
      if (req_log[i].addr !== addr + 32'(4 * i) || req_log[i].op !== op) bad++;
      if (op == WR) begin
        if (i >= wr_data.size() || req_log[i].data !== wr_data[i]) bad++;
      end else if (req_log[i].data !== 32'h0) bad++;
    end
    check({tag, "_req_fields_bad"}, bad, 0);
    if (len > 0 && req_log.size() > 0) check({tag, "_last_addr"}, req_log[$].addr, exp_last);
    if (op == RD) begin
      bad = (rd_log.size() != exp_rd.size()) ? 1 : 0;
      for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
        if (rd_log[i] !== exp_rd[i]) bad++;
      check({tag, "_rd_data_bad"}, bad, 0);
      check({tag, "_credit_viol"}, credit_viol, 0);
    end
    @(negedge QClk);
    check({tag, "_idle_busy"}, {31'b0, BusyQnnnH}, 0);
    check({tag, "_idle_rdvalid"}, {31'b0, RdValidQnnnH}, 0);
  endtask

  typedef struct {
    t_opcode op; logic [31:0] addr; int len; int pct; logic [31:0] d0; logic [31:0] exp_last;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    t_opcode     op;
    logic [31:0] addr;
    int          len, n0;

    vecs[0] = '{RD, 32'hFFFF_FFF8, 3, 100, 32'h0, 32'h0000_0000};
    vecs[1] = '{RD, 32'h0000_1000, 4, 100, 32'h0, 32'h0000_100C};
    vecs[2] = '{WR, 32'hFFFF_FFFC, 2, 50, 32'h55, 32'h0000_0000};
    vecs[3] = '{RD, 32'h0000_0100, 6, 30, 32'h0, 32'h0000_0114};
    vecs[4] = '{RD, 32'h0000_0200, 12, 60, 32'h0, 32'h0000_022C};
    vecs[5] = '{WR, 32'h0000_0300, 7, 100, 32'h10, 32'h0000_0318};

    #1;
    check("rst_busy", {31'b0, BusyQnnnH}, 0);
    check("rst_reqvalid", {31'b0, ReqValidQ501H}, 0);
    check("rst_rdvalid", {31'b0, RdValidQnnnH}, 0);
    repeat (2) @(posedge QClk);
    #1 RstQnnnH = 1'b0;
    @(negedge QClk);
    check("rst_cmdready", {31'b0, CmdReadyQnnnH}, 1);
    check("rst_done", {31'b0, DoneQnnnH}, 0);
    check("rst_wrready", {31'b0, WrReadyQnnnH}, 0);
    check("rst_err", {31'b0, ErrQnnnH}, 0);
    check("rst_erraddr", ErrAddrQnnnH, 0);

    // WR 0x1000 len 4, data 0xA0..0xA3
    start_cmd(WR, 32'h1000, 4, 100, 32'hA0, 1'b0);
    finish_cmd("wr4", WR, 32'h1000, 4, 32'h100C);
    for (int i = 0; i < 4; i++)
      check("wr4_dmem", d_mem[32'h1000 + 32'(4 * i)], 32'hA0 + 32'(i));

    for (int v = 0; v < 6; v++) begin
      start_cmd(vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].pct, vecs[v].d0, 1'b0);
      finish_cmd($sformatf("vec%0d", v), vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].exp_last);
    end

    // RD len 8 with reader stalled: credits cap issue at 4
    start_cmd(RD, 32'h1000, 8, 0, 32'h0, 1'b0);
    repeat (40) @(posedge QClk);
    check("bp_req_cap", req_log.size(), 4);
    check("bp_fifo_full_valid", {31'b0, RdValidQnnnH}, 1);
    repeat (10) @(posedge QClk);
    check("bp_req_hold", req_log.size(), 4);
    rd_pct = 100;
    finish_cmd("bp", RD, 32'h1000, 8, 32'h101C);

    // zero length, both opcodes
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? WR : RD;
      start_cmd(op, 32'h500, 0, 100, 32'h0, 1'b1);
      @(negedge QClk);
      check("len0_done_hi", {31'b0, DoneQnnnH}, 1);
      check("len0_busy_hi", {31'b0, BusyQnnnH}, 1);
      @(negedge QClk);
      check("len0_done_lo", {31'b0, DoneQnnnH}, 0);
      finish_cmd("len0", op, 32'h500, 0, 32'h0);
    end

    // randomized commands
    for (int r = 0; r < 14; r++) begin
      op   = t_opcode'($urandom_range(0, 1));
      addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      len  = $urandom_range(1, 10);
      start_cmd(op, addr, len, $urandom_range(20, 100), 32'h0, 1'b1);
      finish_cmd($sformatf("rnd%0d", r), op, addr, len, addr + 32'(4 * (len - 1)));
    end

    // reset mid-ISSUE of RD len 8
    start_cmd(RD, 32'h3000, 8, 0, 32'h0, 1'b0);
    repeat (3) @(posedge QClk);
    #3 RstQnnnH = 1'b1;
    #1;
    check("midrst_busy", {31'b0, BusyQnnnH}, 0);
    check("midrst_rdvalid", {31'b0, RdValidQnnnH}, 0);
    check("midrst_reqvalid", {31'b0, ReqValidQ501H}, 0);
    @(posedge QClk); #1 RstQnnnH = 1'b0;
    wr_active = 1'b0;
    n0 = req_log.size();
    for (int t = 0; t < 200 && pend.size() > 0; t++) @(posedge QClk);
    repeat (3) @(posedge QClk);
    check("midrst_pend_drained", pend.size(), 0);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_no_req_after", req_log.size(), n0);
    @(negedge QClk);
    check("midrst_fifo_empty", {31'b0, RdValidQnnnH}, 0);
    check("midrst_idle", {31'b0, BusyQnnnH}, 0);
    check("midrst_cmdready", {31'b0, CmdReadyQnnnH}, 1);
    start_cmd(WR, 32'h4000, 1, 100, 32'h77, 1'b0);
    finish_cmd("post_rst_wr", WR, 32'h4000, 1, 32'h4000);
    check("post_rst_wr_dmem", d_mem[32'h4000], 32'h77);

    // second RD response address corrupted
    corrupt_n = 1;
    start_cmd(RD, 32'h5000, 4, 100, 32'h0, 1'b0);
    finish_cmd("err_rd", RD, 32'h5000, 4, 32'h500C);
    corrupt_n = -1;
`ifdef MEM_IO_INIT_ADDR_CHK_EN
    check("err_set", {31'b0, ErrQnnnH}, 1);
    check("err_addr", ErrAddrQnnnH, 32'hDEAD_0000);
    start_cmd(RD, 32'h6000, 3, 100, 32'h0, 1'b0);
    finish_cmd("err_clean", RD, 32'h6000, 3, 32'h6008);
    check("err_sticky", {31'b0, ErrQnnnH}, 1);
    check("err_addr_sticky", ErrAddrQnnnH, 32'hDEAD_0000);
    @(posedge QClk); #1 RstQnnnH = 1'b1;
    @(posedge QClk); #1 RstQnnnH = 1'b0;
    @(negedge QClk);
    check("err_clr", {31'b0, ErrQnnnH}, 0);
    check("err_addr_clr", ErrAddrQnnnH, 0);
`else
    check("err_tied", {31'b0, ErrQnnnH}, 0);
    check("err_addr_tied", ErrAddrQnnnH, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
